fft_butterfly_r2: RTL and testbench

- Radix-2 DIT butterfly stage that consumes the twiddle-coefficient ROM output.
- Takes a complex operand pair (a, b) and a twiddle index.
- Drives the index to the coefficient ROM, aligns the ROM's 1-cycle registered output with the data, and computes x = a + b·W and y = a − b·W.
- Fully pipelined streaming stage, one pair per clock, with optional per-stage scaling, saturation and a sticky overflow flag.

---
 rtl/fft_butterfly_r2.sv | 126 ++++++++++++
 tb/tb_fft_butterfly_r2.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly: x = a + b*W, y = a - b*W.
// Streaming pipeline aligned to a 1-cycle registered twiddle ROM.
module fft_butterfly_r2 #(
   parameter int DATA_W = 16,
   parameter int WIDTH  = 10,
   parameter int N      = 8,
   parameter int SCALE  = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   input  logic signed [DATA_W-1:0] i_a_real,
   input  logic signed [DATA_W-1:0] i_a_imag,
   input  logic signed [DATA_W-1:0] i_b_real,
   input  logic signed [DATA_W-1:0] i_b_imag,
   input  logic [$clog2(N)-2:0]     i_tw_num,
   output logic [$clog2(N)-2:0]     o_tw_num,
   input  logic signed [WIDTH-1:0]  i_coef_real,
   input  logic signed [WIDTH-1:0]  i_coef_imag,
   input  logic                     i_clr_ovf,
   output logic                     o_valid,
   output logic signed [DATA_W-1:0] o_x_real,
   output logic signed [DATA_W-1:0] o_x_imag,
   output logic signed [DATA_W-1:0] o_y_real,
   output logic signed [DATA_W-1:0] o_y_imag,
   output logic                     o_ovf
);

   localparam int PW  = DATA_W + WIDTH;
   localparam int DW2 = DATA_W + 2;
   localparam logic signed [PW:0] RND = (PW+1)'(2**(WIDTH-3));
   localparam logic signed [DW2-1:0] MAXV = DW2'(2**(DATA_W-1) - 1);
   localparam logic signed [DW2-1:0] MINV = DW2'(-(2**(DATA_W-1)));

   logic v0, v1, v2, v3;
   logic signed [DATA_W-1:0] ar0, ai0, br0, bi0;
   logic signed [DATA_W-1:0] ar1, ai1, ar2, ai2;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [DW2-1:0] tr2, ti2;
   logic signed [DW2-1:0] xr3, xi3, yr3, yi3;

   logic signed [PW:0] sr, si;
   logic signed [DW2-1:0] tr_n, ti_n;
   logic signed [DW2-1:0] xr_n, xi_n, yr_n, yi_n;
   logic ovf_n;

   function automatic logic signed [DATA_W-1:0] sat(
      input logic signed [DW2-1:0] v
   );
      if (v > MAXV) return DATA_W'(MAXV);
      else if (v < MINV) return DATA_W'(MINV);
      else return DATA_W'(v);
   endfunction

   function automatic logic ovr(input logic signed [DW2-1:0] v);
      return (v > MAXV) || (v < MINV);
   endfunction

   // the ROM registers the index, so W lines up with S0
   assign o_tw_num = i_tw_num;

   always_comb begin
      sr = (PW+1)'(p_rr) - (PW+1)'(p_ii) + RND;
      si = (PW+1)'(p_ri) + (PW+1)'(p_ir) + RND;
      tr_n = DW2'(sr >>> (WIDTH-2));
      ti_n = DW2'(si >>> (WIDTH-2));
      xr_n = DW2'(ar2) + tr2;
      xi_n = DW2'(ai2) + ti2;
      yr_n = DW2'(ar2) - tr2;
      yi_n = DW2'(ai2) - ti2;
      if (SCALE != 0) begin
         xr_n = xr_n >>> 1;
         xi_n = xi_n >>> 1;
         yr_n = yr_n >>> 1;
         yi_n = yi_n >>> 1;
      end
      ovf_n = ovr(xr3) | ovr(xi3) | ovr(yr3) | ovr(yi3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         ar0 <= '0; ai0 <= '0; br0 <= '0; bi0 <= '0;
         ar1 <= '0; ai1 <= '0; ar2 <= '0; ai2 <= '0;
         p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
         tr2 <= '0; ti2 <= '0;
         xr3 <= '0; xi3 <= '0; yr3 <= '0; yi3 <= '0;
         o_valid <= 1'b0;
         o_x_real <= '0; o_x_imag <= '0;
         o_y_real <= '0; o_y_imag <= '0;
         o_ovf <= 1'b0;
      end else begin
         v0 <= i_valid;
         if (i_valid) begin
            ar0 <= i_a_real; ai0 <= i_a_imag;
            br0 <= i_b_real; bi0 <= i_b_imag;
         end
         v1 <= v0;
         if (v0) begin
            p_rr <= PW'(br0) * PW'(i_coef_real);
            p_ii <= PW'(bi0) * PW'(i_coef_imag);
            p_ri <= PW'(br0) * PW'(i_coef_imag);
            p_ir <= PW'(bi0) * PW'(i_coef_real);
            ar1 <= ar0; ai1 <= ai0;
         end
         v2 <= v1;
         if (v1) begin
            tr2 <= tr_n; ti2 <= ti_n;
            ar2 <= ar1; ai2 <= ai1;
         end
         v3 <= v2;
         if (v2) begin
            xr3 <= xr_n; xi3 <= xi_n;
            yr3 <= yr_n; yi3 <= yi_n;
         end
         o_valid <= v3;
         if (v3) begin
            o_x_real <= sat(xr3); o_x_imag <= sat(xi3);
            o_y_real <= sat(yr3); o_y_imag <= sat(yi3);
         end
         if (v3 && ovf_n) o_ovf <= 1'b1;
         else if (i_clr_ovf) o_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Bench for fft_butterfly_r2: SCALE=0 and SCALE=1 instances side by side,
// checked against an arithmetic scoreboard keyed by output clock edge.
module tb_fft_butterfly_r2;

   localparam int DW = 16;
   localparam int CW = 10;
   localparam int N  = 8;
   localparam int TW = $clog2(N) - 1;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i_valid = 1'b0;
   logic i_clr_ovf = 1'b0;
   logic signed [DW-1:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
   logic [TW-1:0] tw = '0;
   logic [TW-1:0] tw_o[2];
   logic signed [CW-1:0] c_r = '0, c_i = '0;
   logic ov[2], ovf[2];
   logic signed [DW-1:0] xr[2], xi[2], yr[2], yi[2];

   int rom_r[4] = '{256, 181, 0, -181};
   int rom_i[4] = '{0, -181, -256, -181};

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit es[2][DEPTH];
   bit esat[2][DEPTH];
   int ex[2][DEPTH][4];
   bit ovm[2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fft_butterfly_r2 #(
         .DATA_W(DW), .WIDTH(CW), .N(N), .SCALE(g)
      ) dut (
         .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
         .i_a_real(a_r), .i_a_imag(a_i),
         .i_b_real(b_r), .i_b_imag(b_i),
         .i_tw_num(tw), .o_tw_num(tw_o[g]),
         .i_coef_real(c_r), .i_coef_imag(c_i),
         .i_clr_ovf(i_clr_ovf), .o_valid(ov[g]),
         .o_x_real(xr[g]), .o_x_imag(xi[g]),
         .o_y_real(yr[g]), .o_y_imag(yi[g]),
         .o_ovf(ovf[g])
      );
   end

   // twiddle ROM with one cycle of read latency
   always @(posedge clk) begin
      c_r <= CW'(rom_r[tw_o[0]]);
      c_i <= CW'(rom_i[tw_o[0]]);
   end

   task automatic check(string tag, longint got, longint exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int clip(longint v, inout bit f);
      if (v > 32767) begin f = 1'b1; return 32767; end
      if (v < -32768) begin f = 1'b1; return -32768; end
      return int'(v);
   endfunction

   task automatic model(int s, int ar, int ai, int br, int bi,
                        int num, int e);
      longint tr, ti;
      longint sm[4];
      bit f;
      f = 1'b0;
      tr = (longint'(br) * rom_r[num] - longint'(bi) * rom_i[num]
            + 2**(CW-3)) >>> (CW-2);
      ti = (longint'(br) * rom_i[num] + longint'(bi) * rom_r[num]
            + 2**(CW-3)) >>> (CW-2);
      sm[0] = ar + tr; sm[1] = ai + ti;
      sm[2] = ar - tr; sm[3] = ai - ti;
      for (int k = 0; k < 4; k++) begin
         if (s == 1) sm[k] = sm[k] >>> 1;
         ex[s][e][k] = clip(sm[k], f);
      end
      es[s][e] = 1'b1;
      esat[s][e] = f;
   endtask

   task automatic step(bit v, int ar, int ai, int br, int bi,
                       int num, bit clr);
      int e;
      e = cyc + 1;
      i_valid = v;
      a_r = DW'(ar); a_i = DW'(ai);
      b_r = DW'(br); b_i = DW'(bi);
      tw = TW'(num);
      i_clr_ovf = clr;
      if (v) begin
         model(0, ar, ai, br, bi, num, e + 4);
         model(1, ar, ai, br, bi, num, e + 4);
      end
      #1;
      if (v) begin
         check("tw_num s0", tw_o[0], num);
         check("tw_num s1", tw_o[1], num);
      end
      @(posedge clk);
      cyc = e;
      #1;
      for (int s = 0; s < 2; s++) begin
         if (es[s][e] && esat[s][e]) ovm[s] = 1'b1;
         else if (clr) ovm[s] = 1'b0;
         check($sformatf("valid s%0d", s), ov[s], es[s][e]);
         if (es[s][e]) begin
            check($sformatf("x_re s%0d", s), xr[s], ex[s][e][0]);
            check($sformatf("x_im s%0d", s), xi[s], ex[s][e][1]);
            check($sformatf("y_re s%0d", s), yr[s], ex[s][e][2]);
            check($sformatf("y_im s%0d", s), yi[s], ex[s][e][3]);
         end
         check($sformatf("ovf s%0d", s), ovf[s], ovm[s]);
         es[s][e] = 1'b0;
         esat[s][e] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_zero(string tag);
      for (int s = 0; s < 2; s++) begin
         check($sformatf("%s valid s%0d", tag, s), ov[s], 0);
         check($sformatf("%s x_re s%0d", tag, s), xr[s], 0);
         check($sformatf("%s x_im s%0d", tag, s), xi[s], 0);
         check($sformatf("%s y_re s%0d", tag, s), yr[s], 0);
         check($sformatf("%s y_im s%0d", tag, s), yi[s], 0);
         check($sformatf("%s ovf s%0d", tag, s), ovf[s], 0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // directed vectors
      step(1, 100, 0, 50, 0, 0, 0);
      step(1, 0, 0, 0, 64, 2, 0);
      step(1, 0, 0, 100, 0, 1, 0);
      idle(5);

      // saturation, then clear on the same edge as a new set
      step(1, 32767, 0, 32767, 0, 0, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(3);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(2);

      // streaming with a gap
      step(1, 1000, -2000, 300, 400, 1, 0);
      step(1, -500, 700, -1200, 900, 3, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(1, 20000, 15000, 30000, -25000, 2, 0);
      idle(5);

      // flush with an oversize pair so ovf is up before the reset
      step(1, -32768, -32768, 32767, 32767, 3, 0);
      idle(4);
      step(1, 11, 22, 33, 44, 0, 0);
      step(1, 55, 66, 77, 88, 1, 0);
      step(1, 99, -11, -22, 33, 2, 0);
      #2 rst_n = 1'b0;
      #1 check_zero("async rst");
      for (int s = 0; s < 2; s++) begin
         ovm[s] = 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            es[s][k] = 1'b0;
            esat[s][k] = 1'b0;
         end
      end
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 3) != 0,
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 3)),
              $urandom_range(0, 9) == 0);
      end
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
